// File: rtl/edge_detector_block_if.sv
// Signal bundle for edge_detector_block: monitored level in, pulse and
// synchronized level out. The master drives the level, the slave (the
// detector) returns the results.
interface edge_detector_block_if;
  logic signal;
  logic edge_detected;
  logic signal_sync;

  modport master (
    output signal,
    input  edge_detected,
    input  signal_sync
  );

  modport slave (
    input  signal,
    output edge_detected,
    output signal_sync
  );
endinterface : edge_detector_block_if

// File: rtl/edge_detector_block.sv
// edge_detector_block
//   Samples a (possibly asynchronous) level and emits a one-cycle pulse on
//   each qualifying edge: EDGE_TYPE 0 = rising, 1 = falling, 2 = either;
//   any other value behaves as rising.
//
//   Build option EDGE_DETECTOR_SYNC_EN:
//     defined   -> an extra input stage s_in sits in front of s_cur. s_in and
//                  s_cur together form the two-flop metastability
//                  synchronizer, so a new level shows up as a pulse in the
//                  cycle after the 2nd clk edge that sees it.
//     undefined -> s_cur samples the input directly, so a new level shows up
//                  as a pulse in the cycle after the 1st clk edge that sees it.
//
//   The pulse is decoded from s_cur/s_prev only, so it is glitch-free and
//   independent of the raw input. Reset is synchronous and active-high and
//   clears every stage, which also flushes any transition still in flight.
module edge_detector_block #(
  parameter int EDGE_TYPE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  edge_detector_block_if.slave  bus
);

  // Out-of-range edge selections fall back to rising-edge detection.
  localparam int EDGE_SEL = ((EDGE_TYPE == 32'sd1) || (EDGE_TYPE == 32'sd2)) ? EDGE_TYPE : 32'sd0;

  logic s_cur_d;
  logic s_cur_q;
  logic s_prev_d;
  logic s_prev_q;
  logic edge_s;

`ifdef EDGE_DETECTOR_SYNC_EN
  logic s_in_d;
  logic s_in_q;

  // Next-state for the synchronizer front stage and the history pipeline.
  always_comb begin
    s_in_d   = bus.signal;
    s_cur_d  = s_in_q;
    s_prev_d = s_cur_q;
  end

  // Pipeline registers; reset clears all stages so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_in_q   <= 1'b0;
      s_cur_q  <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_in_q   <= s_in_d;
      s_cur_q  <= s_cur_d;
      s_prev_q <= s_prev_d;
    end
  end
`else
  // Next-state for the history pipeline; s_cur samples the input directly.
  always_comb begin
    s_cur_d  = bus.signal;
    s_prev_d = s_cur_q;
  end

  // Pipeline registers; reset clears all stages so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_cur_q  <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_cur_q  <= s_cur_d;
      s_prev_q <= s_prev_d;
    end
  end
`endif

  // Decode the selected edge kind from the current and previous sampled level.
  always_comb begin
    edge_s = 1'b0;
    case (EDGE_SEL)
      32'sd1:  edge_s = ~s_cur_q & s_prev_q;
      32'sd2:  edge_s = s_cur_q ^ s_prev_q;
      default: edge_s = s_cur_q & ~s_prev_q;
    endcase
  end

  assign bus.edge_detected = edge_s;
  assign bus.signal_sync   = s_cur_q;

endmodule : edge_detector_block

// File: tb/tb_edge_detector_block.sv
// Self-checking bench for edge_detector_block. Four instances (EDGE_TYPE 0,
// 1, 2 and out-of-range 3) watch the same input. A reference model logs the
// input level and reset seen at every clk edge and derives the level the
// detector should see from that log plus the pipeline latency.
module tb_edge_detector_block;

`ifdef EDGE_DETECTOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int MAXC = 4096;

  logic clk;
  logic rst;
  logic sig;

  int checks;
  int failures;
  int cyc;
  int last_rst;
  bit samp [0:MAXC-1];
  int cnt0, cnt1, cnt2, cnt3;
  int run2, max_run2;

  edge_detector_block_if if0 ();
  edge_detector_block_if if1 ();
  edge_detector_block_if if2 ();
  edge_detector_block_if if3 ();

  assign if0.signal = sig;
  assign if1.signal = sig;
  assign if2.signal = sig;
  assign if3.signal = sig;

  edge_detector_block #(.EDGE_TYPE(0)) u_rise   (.clk(clk), .rst(rst), .bus(if0));
  edge_detector_block #(.EDGE_TYPE(1)) u_fall   (.clk(clk), .rst(rst), .bus(if1));
  edge_detector_block #(.EDGE_TYPE(2)) u_either (.clk(clk), .rst(rst), .bus(if2));
  edge_detector_block #(.EDGE_TYPE(3)) u_odd    (.clk(clk), .rst(rst), .bus(if3));

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Level s_cur should hold after clk edge k: the input sampled LAT-1 edges
  // earlier, or 0 if that sample was taken at/before the latest reset edge.
  function automatic bit level_at(input int k);
    int idx;
    idx = k - (LAT - 1);
    if (k < 1 || idx < 1 || idx <= last_rst) return 1'b0;
    return samp[idx];
  endfunction

  function automatic void clear_counts();
    cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; run2 = 0; max_run2 = 0;
  endfunction

  // Advance one clk edge, log what the DUT sampled, then check all outputs.
  task automatic step();
    bit c, p;
    @(posedge clk);
    cyc++;
    samp[cyc] = sig;
    if (rst) last_rst = cyc;
    #1;
    c = level_at(cyc);
    p = level_at(cyc - 1);
    check_value("sync",   {31'd0, if0.signal_sync},   {31'd0, c});
    check_value("rise",   {31'd0, if0.edge_detected}, {31'd0, c & ~p});
    check_value("fall",   {31'd0, if1.edge_detected}, {31'd0, ~c & p});
    check_value("either", {31'd0, if2.edge_detected}, {31'd0, c ^ p});
    check_value("type3",  {31'd0, if3.edge_detected}, {31'd0, c & ~p});
    if (if0.edge_detected === 1'b1) cnt0++;
    if (if1.edge_detected === 1'b1) cnt1++;
    if (if3.edge_detected === 1'b1) cnt3++;
    if (if2.edge_detected === 1'b1) begin
      cnt2++;
      run2++;
      if (run2 > max_run2) max_run2 = run2;
    end else begin
      run2 = 0;
    end
  endtask

  initial begin
    bit found;
    int hold;
    checks = 0; failures = 0; cyc = 0; last_rst = -1;
    clear_counts();
    rst = 1'b1;
    sig = 1'b1;

    // Reset held 3 cycles with input high: no pulse, level 0.
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("rst_edge", {31'd0, if0.edge_detected}, 32'd0);
      check_value("rst_sync", {31'd0, if0.signal_sync}, 32'd0);
    end

    // Release with input high: one rising pulse, no falling pulse.
    rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 6; i++) step();
    check_value("rel_rise_cnt", cnt0, 32'd1);
    check_value("rel_fall_cnt", cnt1, 32'd0);
    check_value("rel_sync",     {31'd0, if0.signal_sync}, 32'd1);

    // Constant high for a long time: no pulses at all.
    clear_counts();
    for (int i = 0; i < 20; i++) step();
    check_value("const_cnt", cnt2, 32'd0);

    // Square wave, 8 clk per level, 4 periods.
    sig = 1'b0;
    for (int i = 0; i < 8; i++) step();
    clear_counts();
    for (int per = 0; per < 4; per++) begin
      sig = 1'b1;
      for (int i = 0; i < 8; i++) step();
      sig = 1'b0;
      for (int i = 0; i < 8; i++) step();
    end
    for (int i = 0; i < 4; i++) step();
    check_value("sq_rise_cnt",   cnt0, 32'd4);
    check_value("sq_fall_cnt",   cnt1, 32'd4);
    check_value("sq_either_cnt", cnt2, 32'd8);
    check_value("sq_type3_cnt",  cnt3, 32'd4);

    // Toggle every clk for 6 cycles: 6 back-to-back either-edge pulses.
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      sig = ~sig;
      step();
    end
    for (int i = 0; i < 4; i++) step();
    check_value("tog_either_cnt", cnt2, 32'd6);
    check_value("tog_either_run", max_run2, 32'd6);

    // Sub-period glitch between clk edges is never sampled.
    sig = 1'b0;
    for (int i = 0; i < 4; i++) step();
    clear_counts();
    sig = 1'b1;
    #3;
    sig = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_value("glitch_cnt", cnt2, 32'd0);

    // Reset in the cycle the rising pulse is high, input back to 0.
    sig = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (if0.edge_detected === 1'b1) found = 1'b1;
    end
    check_value("mid_pulse_seen", {31'd0, found}, 32'd1);
    rst = 1'b1;
    sig = 1'b0;
    step();
    check_value("mid_rst_edge", {31'd0, if0.edge_detected}, 32'd0);
    rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 6; i++) step();
    check_value("mid_post_cnt", cnt2, 32'd0);

    // Randomized levels with random hold times and occasional resets,
    // including resets landing on transitions still in the pipeline.
    for (int n = 0; n < 120; n++) begin
      sig  = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
      hold = $urandom_range(1, 4);
      for (int i = 0; i < hold; i++) begin
        step();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_edge_detector_block
